// File: rtl/mem_stage_wait_pkg.sv
// Shared types and sizing helpers for the MEM stage with a wait-state data memory.
package mem_stage_pkg;

  // FSM state: IDLE accepts a new access, BUSY counts down the remaining wait states.
  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } stateT;

  // Word-index width for a memory of 'depth' words (at least one bit).
  function automatic int unsigned idxWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wait-counter width; a zero-latency memory still gets a one-bit counter.
  function automatic int unsigned cntWidth(input int unsigned waitCycles);
    return (waitCycles > 0) ? $clog2(waitCycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_wait_word_array.sv
// Word-addressed data memory: synchronous write, asynchronous read, contents not reset.
module mem_word_array
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned IDX_W = idxWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one word per edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/mem_stage_wait.sv
// MEM pipeline stage with MEM/WB register and a data memory of configurable latency.
// freeze stalls upstream while a multi-cycle access is in flight; the access commits
// on the last cycle of the access with freeze low.
module mem_stage_wait
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbEnIn,
  input  logic              memREnIn,
  input  logic              memWEnIn,
  input  logic [DATA_W-1:0] aluResIn,
  input  logic [DATA_W-1:0] valRmIn,
  input  logic [3:0]        destIn,
  output logic              freeze,
  output logic              wbEnOut,
  output logic              memREnOut,
  output logic [DATA_W-1:0] aluResOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic [3:0]        destOut,
  output logic              addrErr
);

  localparam int unsigned IDX_W = idxWidth(DEPTH);
  localparam int unsigned CNT_W = cntWidth(WAIT_CYCLES);
  localparam logic [DATA_W-1:0] BaseAddr = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] Span     = DATA_W'(4 * DEPTH);
  localparam logic [CNT_W-1:0]  CntInit  = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  stateT             stateQ;
  logic [CNT_W-1:0]  cntQ;
  logic [DATA_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rdData;
  logic              inRange;
  logic              access;
  logic              accErr;
  logic              memWe;

  // Byte offset from the window base wraps modulo 2^DATA_W; bits [1:0] are ignored.
  assign off     = aluResIn - BaseAddr;
  assign inRange = off < Span;
  assign idx     = off[IDX_W+1:2];
  assign access  = memREnIn | memWEnIn;
  // Simultaneous rd+wr is treated as a store but flagged.
  assign accErr  = access & (~inRange | (memREnIn & memWEnIn));

  // Stall while wait states remain; a fresh access only stalls when the memory is slow.
  always_comb begin
    freeze = 1'b0;
    case (stateQ)
      StIdle:  freeze = access && (WAIT_CYCLES != 0);
      StBusy:  freeze = (cntQ != '0);
      default: freeze = 1'b0;
    endcase
  end

  // Store lands only on the commit cycle; reset aborts a pending store.
  assign memWe = ~rst & ~freeze & memWEnIn & inRange;

  mem_word_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) uArray (
    .clk  (clk),
    .we   (memWe),
    .widx (idx),
    .wdata(valRmIn),
    .ridx (idx),
    .rdata(rdData)
  );

  // Wait-state FSM plus MEM/WB register; a bubble is loaded on every stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      cntQ       <= '0;
      wbEnOut    <= 1'b0;
      memREnOut  <= 1'b0;
      aluResOut  <= '0;
      memDataOut <= '0;
      destOut    <= '0;
      addrErr    <= 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (access && (WAIT_CYCLES != 0)) begin
            stateQ <= StBusy;
            cntQ   <= CntInit;
          end
        end
        StBusy: begin
          if (cntQ != '0) begin
            cntQ <= cntQ - CNT_W'(1);
          end else begin
            stateQ <= StIdle;
          end
        end
        default: stateQ <= StIdle;
      endcase

      if (freeze) begin
        wbEnOut   <= 1'b0;
        memREnOut <= 1'b0;
        addrErr   <= 1'b0;
      end else begin
        wbEnOut    <= wbEnIn;
        memREnOut  <= memREnIn;
        aluResOut  <= aluResIn;
        destOut    <= destIn;
        addrErr    <= accErr;
        memDataOut <= (memREnIn & ~memWEnIn & inRange) ? rdData : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_wait.sv
// Bench for mem_stage_wait: unit 0 has single-cycle memory, unit 1 has three wait states.
// A word-level memory model predicts every MEM/WB value and the freeze timeline.
module tb_mem_stage_wait;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbEnIn[2], memREnIn[2], memWEnIn[2];
  logic [31:0] aluResIn[2], valRmIn[2];
  logic [3:0]  destIn[2];
  logic        freeze[2], wbEnOut[2], memREnOut[2], addrErr[2];
  logic [31:0] aluResOut[2], memDataOut[2];
  logic [3:0]  destOut[2];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model[2][64];

  always #5 clk = ~clk;

  mem_stage_wait #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut0 (
    .clk(clk), .rst(rst), .wbEnIn(wbEnIn[0]), .memREnIn(memREnIn[0]), .memWEnIn(memWEnIn[0]),
    .aluResIn(aluResIn[0]), .valRmIn(valRmIn[0]), .destIn(destIn[0]), .freeze(freeze[0]),
    .wbEnOut(wbEnOut[0]), .memREnOut(memREnOut[0]), .aluResOut(aluResOut[0]),
    .memDataOut(memDataOut[0]), .destOut(destOut[0]), .addrErr(addrErr[0])
  );

  mem_stage_wait #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(3), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(rst), .wbEnIn(wbEnIn[1]), .memREnIn(memREnIn[1]), .memWEnIn(memWEnIn[1]),
    .aluResIn(aluResIn[1]), .valRmIn(valRmIn[1]), .destIn(destIn[1]), .freeze(freeze[1]),
    .wbEnOut(wbEnOut[1]), .memREnOut(memREnOut[1]), .aluResOut(aluResOut[1]),
    .memDataOut(memDataOut[1]), .destOut(destOut[1]), .addrErr(addrErr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs(input int u);
    wbEnIn[u]   = 1'b0;
    memREnIn[u] = 1'b0;
    memWEnIn[u] = 1'b0;
    aluResIn[u] = '0;
    valRmIn[u]  = '0;
    destIn[u]   = '0;
  endtask

  task automatic checkAllZero(input int u, input string tag);
    chk($sformatf("%s u%0d wbEnOut", tag, u), 32'(wbEnOut[u]), 32'd0);
    chk($sformatf("%s u%0d memREnOut", tag, u), 32'(memREnOut[u]), 32'd0);
    chk($sformatf("%s u%0d aluResOut", tag, u), aluResOut[u], 32'd0);
    chk($sformatf("%s u%0d memDataOut", tag, u), memDataOut[u], 32'd0);
    chk($sformatf("%s u%0d destOut", tag, u), 32'(destOut[u]), 32'd0);
    chk($sformatf("%s u%0d addrErr", tag, u), 32'(addrErr[u]), 32'd0);
  endtask

  // Present one operation on unit u and hold it until it commits; called just after a
  // rising edge and returns just after the commit edge with that unit's inputs cleared.
  task automatic doOp(input int u, input string tag, input logic rd, input logic wr,
                      input logic wb, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] dest);
    int unsigned waits;
    logic [31:0] off;
    logic        inR;
    logic [5:0]  idx;
    logic [31:0] expData;
    logic        expErr;
    off     = addr - 32'd1024;
    inR     = off < 32'd256;
    idx     = off[7:2];
    waits   = (rd || wr) ? ((u == 0) ? 0 : 3) : 0;
    expData = (rd && !wr && inR) ? model[u][idx] : 32'd0;
    expErr  = (rd || wr) && (!inR || (rd && wr));
    wbEnIn[u]   = wb;
    memREnIn[u] = rd;
    memWEnIn[u] = wr;
    aluResIn[u] = addr;
    valRmIn[u]  = data;
    destIn[u]   = dest;
    for (int c = 0; c <= int'(waits); c++) begin
      @(negedge clk);
      chk($sformatf("%s u%0d freeze c%0d", tag, u, c), 32'(freeze[u]),
          32'(c < int'(waits)));
      @(posedge clk);
      #1;
      if (c < int'(waits)) begin
        chk($sformatf("%s u%0d bubble wbEn", tag, u), 32'(wbEnOut[u]), 32'd0);
        chk($sformatf("%s u%0d bubble memREn", tag, u), 32'(memREnOut[u]), 32'd0);
        chk($sformatf("%s u%0d bubble addrErr", tag, u), 32'(addrErr[u]), 32'd0);
      end
    end
    chk($sformatf("%s u%0d wbEnOut", tag, u), 32'(wbEnOut[u]), 32'(wb));
    chk($sformatf("%s u%0d memREnOut", tag, u), 32'(memREnOut[u]), 32'(rd));
    chk($sformatf("%s u%0d aluResOut", tag, u), aluResOut[u], addr);
    chk($sformatf("%s u%0d memDataOut", tag, u), memDataOut[u], expData);
    chk($sformatf("%s u%0d destOut", tag, u), 32'(destOut[u]), 32'(dest));
    chk($sformatf("%s u%0d addrErr", tag, u), 32'(addrErr[u]), 32'(expErr));
    if (wr && inR) model[u][idx] = data;
    clearInputs(u);
  endtask

  initial begin
    logic [31:0] addr;
    logic        rd, wr;
    clearInputs(0);
    clearInputs(1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      checkAllZero(u, "reset");
      chk($sformatf("reset u%0d freeze", u), 32'(freeze[u]), 32'd0);
    end

    // Fill both memories so every later load has a defined value.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 64; i++) begin
        doOp(u, "fill", 1'b0, 1'b1, 1'b0, 32'd1024 + 32'(4 * i), $urandom, 4'd0);
      end
    end

    // Single-cycle store then load.
    doOp(0, "t1st", 1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 4'd1);
    doOp(0, "t1ld", 1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd2);
    chk("t1 data", memDataOut[0], 32'hDEADBEEF);

    // Slow load: three stall cycles then commit.
    doOp(1, "t2ld", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd3);

    // Back-to-back store then load to the same word.
    doOp(1, "t3st", 1'b0, 1'b1, 1'b0, 32'd1032, 32'h1234_5678, 4'd4);
    doOp(1, "t3ld", 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd5);
    chk("t3 data", memDataOut[1], 32'h1234_5678);

    // Out-of-range store and load, both rd+wr, then confirm word 0 untouched.
    doOp(1, "t4st", 1'b0, 1'b1, 1'b0, 32'd1024 + 32'd256, 32'hBAD0BAD0, 4'd6);
    doOp(1, "t4ld", 1'b1, 1'b0, 1'b1, 32'd1020, 32'd0, 4'd6);
    doOp(0, "t4both", 1'b1, 1'b1, 1'b1, 32'd1036, 32'hCAFE0001, 4'd8);
    doOp(1, "t4chk", 1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd9);

    // Reset on the second stall cycle of a store: the store is dropped.
    wbEnIn[1]   = 1'b0;
    memWEnIn[1] = 1'b1;
    aluResIn[1] = 32'd1040;
    valRmIn[1]  = 32'h5555_AAAA;
    @(negedge clk);
    chk("t5 freeze first", 32'(freeze[1]), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearInputs(1);
    checkAllZero(1, "t5");
    checkAllZero(0, "t5");
    @(negedge clk);
    chk("t5 freeze after", 32'(freeze[1]), 32'd0);
    @(posedge clk);
    #1;
    doOp(1, "t5ld", 1'b1, 1'b0, 1'b1, 32'd1040, 32'd0, 4'd10);

    // Plain ALU op passes through.
    doOp(0, "t6", 1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 4'd7);
    doOp(1, "t6", 1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 4'd7);

    // Randomized mix of loads, stores, errors and ALU ops on both units.
    for (int n = 0; n < 240; n++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = 32'd1024 + 32'(4 * $urandom_range(0, 68)) + 32'($urandom_range(0, 3));
      doOp(n % 2, "rand", rd, wr, 1'($urandom), addr, $urandom, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
